// File: rtl/leb128_pkg.sv
// Shared constants and types for the signed-LEB128 int32 decode path.
package leb128_pkg;
  localparam int LEB_CONT_BIT      = 7;
  localparam int LEB_SIGN_BIT      = 6;
  localparam int LEB_I32_MAX_BYTES = 5;
  localparam int LEB_PAYLOAD_BITS  = 7;

  typedef logic [7:0] leb_byte_t;
endpackage

// File: rtl/leb128_i32_stream_aligner_if.sv
// Byte-in / value-out handshake bundle for the LEB128 stream aligner.
// A transfer happens on a rising edge where valid & ready are both high; the
// source holds its payload stable while valid & !ready, and ready never
// depends combinationally on valid from the other side.
interface leb128_i32_stream_aligner_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_len, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_len, out_err, out_valid
  );
endinterface

// File: rtl/unpack_i32.sv
// Combinational signed-LEB128 decode of a 5-byte window starting at a value boundary.
module unpack_i32
  import leb128_pkg::*;
(
  input  leb_byte_t   i0,
  input  leb_byte_t   i1,
  input  leb_byte_t   i2,
  input  leb_byte_t   i3,
  input  leb_byte_t   i4,
  output logic [31:0] value
);
    leb_byte_t   w [LEB_I32_MAX_BYTES];
    logic        done;
    logic [31:0] acc;

    always_comb begin
        w[0] = i0;
        w[1] = i1;
        w[2] = i2;
        w[3] = i3;
        w[4] = i4;
        acc  = '0;
        done = 1'b0;
        for (int k = 0; k < LEB_I32_MAX_BYTES; k++) begin
            if (!done) begin
                acc = acc | (32'(w[k][LEB_PAYLOAD_BITS-1:0]) << (LEB_PAYLOAD_BITS * k));
                if (!w[k][LEB_CONT_BIT]) begin
                    done = 1'b1;
                    // A 5-byte value already spans all 32 bits, so only shorter ones need extension.
                    if (w[k][LEB_SIGN_BIT] && (k < LEB_I32_MAX_BYTES - 1)) begin
                        acc = acc | ~((32'd1 << (LEB_PAYLOAD_BITS * (k + 1))) - 32'd1);
                    end
                end
            end
        end
        value = acc;
    end
endmodule

// File: rtl/leb128_i32_stream_aligner.sv
// Buffers a signed-LEB128 byte stream and emits one decoded int32 per value,
// popping exactly the bytes that value occupied.
module leb128_i32_stream_aligner
  import leb128_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  leb128_i32_stream_aligner_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][7:0] bytes_q, bytes_d, bytes_shift;
    logic [CW-1:0]         count_q, count_d, wr_idx;
    logic [4:0]            live;
    leb_byte_t             win [LEB_I32_MAX_BYTES];
    logic                  t_found;
    logic [2:0]            t_idx;
    logic                  raw_valid;
    logic [2:0]            raw_len;
    logic [31:0]           dec_value;
    logic                  push, pop;
    logic [2:0]            pop_len;

    // Terminator search over the first five buffered bytes; empty slots read as 0x00.
    always_comb begin
        live    = '0;
        t_found = 1'b0;
        t_idx   = 3'd0;
        for (int k = 0; k < LEB_I32_MAX_BYTES; k++) begin
            live[k] = (count_q > CW'(k));
            win[k]  = live[k] ? bytes_q[k] : 8'h00;
            if (!t_found && live[k] && !bytes_q[k][LEB_CONT_BIT]) begin
                t_found = 1'b1;
                t_idx   = 3'(k);
            end
        end
    end

    assign raw_valid = t_found || (count_q >= CW'(LEB_I32_MAX_BYTES));
    assign raw_len   = t_found ? (t_idx + 3'd1) : 3'(LEB_I32_MAX_BYTES);

    unpack_i32 u_unpack (
        .i0    (win[0]),
        .i1    (win[1]),
        .i2    (win[2]),
        .i3    (win[3]),
        .i4    (win[4]),
        .value (dec_value)
    );

    assign bus.in_ready  = !rst && (count_q < CW'(DEPTH));
    assign bus.out_valid = !rst && raw_valid;
    assign bus.out_err   = !rst && !t_found;
    assign bus.out_len   = rst ? 3'd0 : raw_len;
    assign bus.out_data  = rst ? 32'd0 : dec_value;

    assign push    = bus.in_valid && bus.in_ready;
    assign pop     = bus.out_valid && bus.out_ready;
    assign pop_len = pop ? bus.out_len : 3'd0;

    // Shift out the popped value, then append the incoming byte just past what remains.
    always_comb begin
        bytes_shift = bytes_q >> {pop_len, 3'b000};
        wr_idx      = count_q - CW'(pop_len);
        bytes_d     = bytes_shift;
        if (push) begin
            bytes_d[wr_idx] = bus.in_data;
        end
        count_d = count_q - CW'(pop_len) + CW'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_q <= '0;
            count_q <= '0;
        end else begin
            bytes_q <= bytes_d;
            count_q <= count_d;
        end
    end
endmodule

// File: doc/leb128_i32_stream_aligner.md
Name: leb128_i32_stream_aligner

Overview:
Upstream feeder for unpack_i32. Accepts a signed-LEB128 byte stream, one byte per cycle, under a valid/ready handshake. Buffers the bytes and presents a 5-byte window aligned to the start of the next encoded value to an internal unpack_i32 instance. Emits each decoded 32-bit value with its byte length over a valid/ready handshake, then pops exactly that many bytes.

Parameters:
DEPTH, 8, byte buffer capacity; legal range 5..16.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_data  in  8  LEB128 byte
in_valid  in  1  in_data valid
in_ready  out  1  buffer can accept a byte this cycle
out_data  out  32  decoded signed value
out_len  out  3  bytes consumed by this value (1..5)
out_err  out  1  value is overlong (5th byte has continuation bit set)
out_valid  out  1  complete value available
out_ready  in  1  downstream accepts value

Behaviour:
- Reset: synchronous, active-high. Clears count to 0 and all buffer bytes to 0x00.
  - Outputs while rst=1: in_ready=0, out_valid=0, out_err=0, out_len=0, out_data=0.
  - rst mid-value discards all buffered bytes, including partial values.
- State: buffer b[0..DEPTH-1], b[0] = oldest byte; count 0..DEPTH.
- Push: in_valid & in_ready.
  - in_ready = !rst & (count < DEPTH).
  - in_ready is registered-state only; it has no combinational path from out_ready.
- Terminator position t = lowest k in 0..4 with k < count and b[k][7]=0.
- Completion:
  - out_valid = 1 when t exists, or when count >= 5.
  - Otherwise out_valid = 0.
- Length:
  - out_len = t+1 when t exists.
  - Otherwise out_len = 5 and out_err = 1.
  - out_err = 0 whenever t exists.
- Decoding:
  - Window i0..i4 = b[0..4]; positions >= count are forced to 0x00.
  - out_data = unpack_i32 output on that window.
  - When out_err=1, out_data is the unpack_i32 result on the 5 bytes and is don't-care for checking.
- Latency: a byte pushed in cycle N is visible in the buffer at N+1. A terminating byte pushed at N gives out_valid=1 at N+1 at the earliest.
- Hold: while out_valid & !out_ready, out_data, out_len and out_err stay stable. Pushes may still occur; they only append beyond the current value.
- Pop: out_valid & out_ready.
  - Buffer shifts down by out_len.
  - count_next = count - pop_len + push.
  - On simultaneous push and pop, the new byte lands at index count - pop_len.
- Back-to-back: after a pop, the next value is presented the following cycle if it is already complete in the buffer.
- Full: count = DEPTH forces in_ready=0. A pop that same cycle raises in_ready in the next cycle, not the same cycle.
- Empty: count = 0 gives out_valid=0.
- Ordering: values are emitted strictly in stream order; no byte is dropped or duplicated.

Decomposition:
- Shared package leb128_pkg holds:
  - LEB_CONT_BIT = 7
  - LEB_SIGN_BIT = 6
  - LEB_I32_MAX_BYTES = 5
  - LEB_PAYLOAD_BITS = 7
- One sub-module: unpack_i32, instantiated unmodified as the combinational decode stage.
- Terminator search and the shift/append buffer stay inline in this block.

Test Plan:
- Single bytes 0x3F, then 0x40, out_ready=1 -> out_data 0x0000003F len 1, then 0xFFFFFFC0 len 1, out_err=0.
- Stream E5 8E 26 C0 BB 78 -> 0x00098765 len 3, then 0xFFFE1DC0 (-123456) len 3, back-to-back cycles.
- Hold out_ready=0 while streaming 8 values of 0x01 with DEPTH=8:
  - count reaches 8, then in_ready=0, and out_data stays 0x1 len 1 throughout.
  - Raise out_ready: 8 values of 0x1 emitted over 8 cycles, in_ready rises one cycle after the first pop.
- Overlong 80 80 80 80 80 then 05 -> out_err=1 len 5, then 0x00000005 len 1 with out_err=0.
- Simultaneous push/pop: buffer holds 7F 01 (count 2), push 02 while popping 7F -> next outputs 0x00000001, then 0x00000002, count consistent.
- Reset mid-value: push 80 80, pulse rst for one cycle, push 05 -> single output 0x00000005 len 1; no stale bytes emitted.
